// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default sample width, frame length, sample type
// and the bit-slot wrap helper used by the transmitter.
package i2s_pkg;

  localparam int DEFAULT_SAMPLE_DEPTH = 16;
  localparam int FRAME_BITS = 2 * DEFAULT_SAMPLE_DEPTH;

  typedef logic signed [DEFAULT_SAMPLE_DEPTH-1:0] sample_t;

  function automatic int unsigned next_slot(input int unsigned cnt,
                                            input int unsigned frame_bits);
    return (cnt + 1 >= frame_bits) ? 0 : cnt + 1;
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-pair valid/ready handshake into the I2S transmitter.
interface i2s_tx_if
  import i2s_pkg::*;
#(
  parameter int SAMPLE_DEPTH = DEFAULT_SAMPLE_DEPTH
);

  logic [SAMPLE_DEPTH-1:0] tx_data_l;
  logic [SAMPLE_DEPTH-1:0] tx_data_r;
  logic                    tx_data_valid;
  logic                    tx_data_ready;

  modport master (
    output tx_data_l,
    output tx_data_r,
    output tx_data_valid,
    input  tx_data_ready
  );

  modport slave (
    input  tx_data_l,
    input  tx_data_r,
    input  tx_data_valid,
    output tx_data_ready
  );

endinterface

// File: rtl/i2s_clkgen.sv
// Bit-clock generator: divides mclk into a 50% duty bclk and exposes the
// mclk-cycle strobes that precede each bclk edge.
module i2s_clkgen #(
  parameter int BCLK_DIV = 4
) (
  input  logic mclk,
  input  logic reset_n,
  output logic bclk,
  output logic fall_evt,
  output logic rise_evt
);

  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          term;

  assign term     = (div_cnt == CW'(BCLK_DIV - 1));
  assign fall_evt = term && bclk;
  assign rise_evt = term && !bclk;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (term) begin
      div_cnt <= '0;
      bclk    <= !bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: single-entry holding register feeding a frame
// shifter that drives wclk/dout in step with the generated bclk.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_DEPTH = DEFAULT_SAMPLE_DEPTH,
  parameter int BCLK_DIV     = 4
) (
  input  logic     mclk,
  input  logic     reset_n,
  i2s_tx_if.slave  tx,
  output logic     bclk,
  output logic     wclk,
  output logic     dout,
  output logic     underflow
);

  localparam int FB = 2 * SAMPLE_DEPTH;
  localparam int CW = $clog2(FB);

  logic                    fall_evt;
  logic                    rise_evt;
  logic [CW-1:0]           bit_cnt;
  logic [CW-1:0]           k;
  logic [FB-1:0]           shift;
  logic [SAMPLE_DEPTH-1:0] hold_l;
  logic [SAMPLE_DEPTH-1:0] hold_r;
  logic                    hold_full;
  logic                    hold_next;
  logic                    transfer;
  logic                    load;

  i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .bclk     (bclk),
    .fall_evt (fall_evt),
    .rise_evt (rise_evt)
  );

  assign k         = CW'(next_slot(32'(bit_cnt), FB));
  assign load      = fall_evt && (k == CW'(1));
  assign transfer  = tx.tx_data_valid && tx.tx_data_ready;
  // A transfer in the same cycle as an empty-register load must survive it.
  assign hold_next = transfer ? 1'b1 : (load ? 1'b0 : hold_full);

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= CW'(FB - 1);
      wclk      <= 1'b0;
      dout      <= 1'b0;
      shift     <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (fall_evt) begin
        bit_cnt <= k;
        wclk    <= (k < CW'(SAMPLE_DEPTH));
        if (k == CW'(1)) begin
          shift     <= hold_full ? {hold_l, hold_r} : '0;
          dout      <= hold_full && hold_l[SAMPLE_DEPTH-1];
          underflow <= !hold_full;
        end else begin
          shift <= {shift[FB-2:0], 1'b0};
          dout  <= shift[FB-2];
        end
      end
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full        <= 1'b0;
      hold_l           <= '0;
      hold_r           <= '0;
      tx.tx_data_ready <= 1'b0;
    end else begin
      hold_full        <= hold_next;
      tx.tx_data_ready <= !hold_next;
      if (transfer) begin
        hold_l <= tx.tx_data_l;
        hold_r <= tx.tx_data_r;
      end
    end
  end

  // Both strobes derive from one terminal count, so they never coincide.
  assert property (@(posedge mclk) disable iff (!reset_n) !(fall_evt && rise_evt));

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two instances (BCLK_DIV 4 and 2) behind a select mux,
// a bit-level I2S receiver model and handshake/underflow monitors.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int SD = DEFAULT_SAMPLE_DEPTH;

  logic mclk = 1'b0;
  logic reset_n;
  always #5 mclk = ~mclk;

  i2s_tx_if #(.SAMPLE_DEPTH(SD)) ifc4 ();
  i2s_tx_if #(.SAMPLE_DEPTH(SD)) ifc2 ();

  logic    sel;
  sample_t drv_l, drv_r;
  logic    drv_valid;
  logic    bclk4, wclk4, dout4, uf4;
  logic    bclk2, wclk2, dout2, uf2;
  logic    bclk_m, wclk_m, dout_m, uf_m, ready_m;

  assign ifc4.tx_data_l     = drv_l;
  assign ifc4.tx_data_r     = drv_r;
  assign ifc4.tx_data_valid = drv_valid && !sel;
  assign ifc2.tx_data_l     = drv_l;
  assign ifc2.tx_data_r     = drv_r;
  assign ifc2.tx_data_valid = drv_valid && sel;

  assign bclk_m  = sel ? bclk2 : bclk4;
  assign wclk_m  = sel ? wclk2 : wclk4;
  assign dout_m  = sel ? dout2 : dout4;
  assign uf_m    = sel ? uf2 : uf4;
  assign ready_m = sel ? ifc2.tx_data_ready : ifc4.tx_data_ready;

  i2s_tx #(.SAMPLE_DEPTH(SD), .BCLK_DIV(4)) dut4 (
    .mclk(mclk), .reset_n(reset_n), .tx(ifc4.slave),
    .bclk(bclk4), .wclk(wclk4), .dout(dout4), .underflow(uf4)
  );

  i2s_tx #(.SAMPLE_DEPTH(SD), .BCLK_DIV(2)) dut2 (
    .mclk(mclk), .reset_n(reset_n), .tx(ifc2.slave),
    .bclk(bclk2), .wclk(wclk2), .dout(dout2), .underflow(uf2)
  );

  int vectors = 0;
  int miscompares = 0;

  // Handshake / underflow / dout-edge statistics, sampled mid-cycle.
  int   uf_cnt = 0, uf_wide = 0, uf_wclk_low = 0;
  int   dout_ones = 0, dout_chg = 0, dout_bad = 0;
  logic prev_dout = 1'b0, prev_bclk = 1'b0, prev_uf = 1'b0, prev_rst = 1'b0;
  logic [31:0] acc_q[$];

  always @(negedge mclk) begin
    if (reset_n && prev_rst) begin
      if (uf_m) begin
        uf_cnt++;
        if (prev_uf) uf_wide++;
        if (!wclk_m) uf_wclk_low++;
      end
      if (dout_m) dout_ones++;
      if (dout_m !== prev_dout) begin
        dout_chg++;
        if (!(prev_bclk && !bclk_m)) dout_bad++;
      end
      if (drv_valid && ready_m) acc_q.push_back({drv_l, drv_r});
    end
    prev_dout = dout_m;
    prev_bclk = bclk_m;
    prev_uf   = uf_m;
    prev_rst  = reset_n;
  end

  // Receiver model: a word ends on the bit where wclk is first seen changed.
  logic [SD-1:0] dsh, dl;
  logic          dlast, dhave;
  logic [31:0]   dec_q[$];

  always @(posedge bclk_m or negedge reset_n) begin
    if (!reset_n) begin
      dsh   = '0;
      dlast = 1'b0;
      dhave = 1'b0;
    end else begin
      dsh = {dsh[SD-2:0], dout_m};
      if (wclk_m !== dlast) begin
        if (dlast) begin
          dl    = dsh;
          dhave = 1'b1;
        end else if (dhave) begin
          dec_q.push_back({dl, dsh});
          dhave = 1'b0;
        end
      end
      dlast = wclk_m;
    end
  end

  function automatic int nz_count(input int start);
    int n = 0;
    for (int i = start; i < dec_q.size(); i++)
      if (dec_q[i] != 32'h0) n++;
    return n;
  endfunction

  function automatic logic [31:0] nz_at(input int start, input int idx);
    int n = 0;
    for (int i = start; i < dec_q.size(); i++)
      if (dec_q[i] != 32'h0) begin
        if (n == idx) return dec_q[i];
        n++;
      end
    return 32'h0;
  endfunction

  function automatic logic [31:0] rand_pair();
    logic [31:0] p = $urandom;
    if (p == 32'h0) p = 32'h1;
    return p;
  endfunction

  task automatic hold_reset(input logic s);
    @(posedge mclk); #1;
    drv_valid = 1'b0;
    reset_n   = 1'b0;
    sel       = s;
    repeat (4) @(posedge mclk);
    @(negedge mclk);
    reset_n = 1'b1;
  endtask

  task automatic send_pair(input logic [31:0] p, output bit ok);
    int n = 0;
    ok = 1'b0;
    @(posedge mclk); #1;
    {drv_l, drv_r} = p;
    drv_valid = 1'b1;
    while (!ok && n < 1000) begin
      @(negedge mclk);
      if (ready_m) ok = 1'b1;
      @(posedge mclk); #1;
      n++;
    end
    drv_valid = 1'b0;
  endtask

  task automatic observe(input int ncyc, output int bper, output int wper);
    int   lb = -1, lw = -1;
    logic pb, pw;
    bper = 0; wper = 0;
    pb = bclk_m; pw = wclk_m;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge mclk); #1;
      if (bclk_m && !pb) begin if (lb >= 0) bper = c - lb; lb = c; end
      if (wclk_m && !pw) begin if (lw >= 0) wper = c - lw; lw = c; end
      pb = bclk_m; pw = wclk_m;
    end
  endtask

  task automatic test_reset();
    int bper, wper, uf0, ufw0, ufl0, do0, db0, s0;
    drv_valid = 1'b0; sel = 1'b0; reset_n = 1'b0;
    repeat (3) @(posedge mclk); #1;
    vectors++;
    if ({bclk_m, wclk_m, dout_m, uf_m, ready_m} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000", {bclk_m, wclk_m, dout_m, uf_m, ready_m});
    end
    @(negedge mclk); reset_n = 1'b1;
    uf0 = uf_cnt; ufw0 = uf_wide; ufl0 = uf_wclk_low; do0 = dout_ones; db0 = dout_bad; s0 = dec_q.size();
    #1; vectors++;
    if (ready_m !== 1'b0) begin miscompares++; $display("[TB] FAIL ready_at_release: got %b expected 0", ready_m); end
    @(posedge mclk); #1; vectors++;
    if (ready_m !== 1'b1) begin miscompares++; $display("[TB] FAIL ready_after_release: got %b expected 1", ready_m); end
    observe(600, bper, wper);
    vectors++;
    if (bper != 8) begin miscompares++; $display("[TB] FAIL bclk_period: got %0d expected 8", bper); end
    vectors++;
    if (wper != 256) begin miscompares++; $display("[TB] FAIL wclk_period: got %0d expected 256", wper); end
    vectors++;
    if (uf_cnt - uf0 != 3) begin miscompares++; $display("[TB] FAIL reset_underflows: got %0d expected 3", uf_cnt - uf0); end
    vectors++;
    if ((uf_wide - ufw0) + (uf_wclk_low - ufl0) != 0) begin
      miscompares++;
      $display("[TB] FAIL underflow_shape: got %0d bad pulses expected 0", (uf_wide - ufw0) + (uf_wclk_low - ufl0));
    end
    vectors++;
    if (dout_ones - do0 != 0 || dout_bad - db0 != 0) begin
      miscompares++;
      $display("[TB] FAIL idle_dout: got %0d ones expected 0", dout_ones - do0);
    end
    vectors++;
    if (dec_q.size() - s0 != 2 || nz_count(s0) != 0) begin
      miscompares++;
      $display("[TB] FAIL zero_frames: got %0d frames (%0d nonzero) expected 2 (0)", dec_q.size() - s0, nz_count(s0));
    end
  endtask

  task automatic test_loopback();
    int s0, a0;
    bit ok;
    s0 = dec_q.size(); a0 = acc_q.size();
    send_pair(32'hA5C3_3C5A, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL loopback_accept: got timeout expected accept"); end
    repeat (3 * 256) @(posedge mclk);
    vectors++;
    if (acc_q.size() - a0 != 1) begin miscompares++; $display("[TB] FAIL loopback_accepts: got %0d expected 1", acc_q.size() - a0); end
    vectors++;
    if (nz_count(s0) != 1 || nz_at(s0, 0) !== 32'hA5C3_3C5A) begin
      miscompares++;
      $display("[TB] FAIL loopback_data: got %0d x %h expected 1 x a5c33c5a", nz_count(s0), nz_at(s0, 0));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sent[8];
    int s0, a0, db0, timeouts = 0, not_low = 0, first = -1, n;
    bit got;
    s0 = dec_q.size(); a0 = acc_q.size(); db0 = dout_bad;
    @(posedge mclk); #1;
    drv_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sent[i] = rand_pair();
      {drv_l, drv_r} = sent[i];
      n = 0; got = 1'b0;
      while (!got && n < 600) begin
        @(negedge mclk);
        got = ready_m;
        @(posedge mclk); #1;
        n++;
      end
      if (!got) timeouts++;
      @(negedge mclk);
      if (ready_m) not_low++;
    end
    drv_valid = 1'b0;
    repeat (3 * 256) @(posedge mclk);
    vectors++;
    if (timeouts != 0) begin miscompares++; $display("[TB] FAIL b2b_timeouts: got %0d expected 0", timeouts); end
    vectors++;
    if (not_low != 0) begin miscompares++; $display("[TB] FAIL b2b_ready_low: got %0d high expected 0", not_low); end
    vectors++;
    if (acc_q.size() - a0 != 8) begin miscompares++; $display("[TB] FAIL b2b_accepts: got %0d expected 8", acc_q.size() - a0); end
    vectors++;
    if (nz_count(s0) != 8) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d expected 8", nz_count(s0)); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (nz_at(s0, i) !== sent[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b_pair%0d: got %h expected %h", i, nz_at(s0, i), sent[i]);
      end
    end
    for (int i = s0; i < dec_q.size(); i++)
      if (first < 0 && dec_q[i] != 32'h0) first = i;
    vectors++;
    if (first < 0 || first + 7 >= dec_q.size() || dec_q[first + 7] !== sent[7]) begin
      miscompares++;
      $display("[TB] FAIL b2b_contiguous: got index %0d expected 8 adjacent frames", first);
    end
    vectors++;
    if (dout_bad - db0 != 0) begin miscompares++; $display("[TB] FAIL b2b_dout_edge: got %0d stray edges expected 0", dout_bad - db0); end
  endtask

  task automatic test_underflow();
    int uf0, ufw0, do0, s0;
    logic [31:0] p;
    bit ok;
    repeat (256) @(posedge mclk); #1;
    uf0 = uf_cnt; ufw0 = uf_wide; do0 = dout_ones;
    repeat (512) @(posedge mclk); #1;
    vectors++;
    if (uf_cnt - uf0 != 2 || uf_wide - ufw0 != 0) begin
      miscompares++;
      $display("[TB] FAIL underflow_pulses: got %0d (wide %0d) expected 2 (0)", uf_cnt - uf0, uf_wide - ufw0);
    end
    vectors++;
    if (dout_ones - do0 != 0) begin miscompares++; $display("[TB] FAIL underflow_dout: got %0d ones expected 0", dout_ones - do0); end
    s0 = dec_q.size();
    p = rand_pair();
    send_pair(p, ok);
    repeat (3 * 256) @(posedge mclk);
    vectors++;
    if (!ok || nz_count(s0) != 1 || nz_at(s0, 0) !== p) begin
      miscompares++;
      $display("[TB] FAIL after_underflow: got %0d x %h expected 1 x %h", nz_count(s0), nz_at(s0, 0), p);
    end
  endtask

  task automatic test_reset_mid();
    int bper, wper, n = 0, uf0, do0, s0;
    bit ok;
    send_pair({rand_pair() | 32'h0001_0000} | 32'h0000_FFFF, ok);
    while (!ready_m && n < 600) begin @(posedge mclk); #1; n++; end
    while (wclk_m && n < 900) begin @(posedge mclk); #1; n++; end
    while (!(bclk_m && dout_m && !wclk_m) && n < 1000) begin @(posedge mclk); #1; n++; end
    vectors++;
    if (!ok || n >= 1000) begin miscompares++; $display("[TB] FAIL mid_setup: got %0d cycles expected right slot reached", n); end
    #2 reset_n = 1'b0;
    #1; vectors++;
    if ({bclk_m, wclk_m, dout_m, uf_m, ready_m} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_outputs: got %b expected 00000", {bclk_m, wclk_m, dout_m, uf_m, ready_m});
    end
    repeat (3) @(posedge mclk);
    @(negedge mclk); reset_n = 1'b1;
    uf0 = uf_cnt; do0 = dout_ones; s0 = dec_q.size();
    @(posedge mclk); #1; vectors++;
    if (ready_m !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_ready: got %b expected 1", ready_m); end
    observe(600, bper, wper);
    vectors++;
    if (bper != 8 || wper != 256) begin
      miscompares++;
      $display("[TB] FAIL mid_timing: got %0d/%0d expected 8/256", bper, wper);
    end
    vectors++;
    if (uf_cnt - uf0 != 3 || dout_ones - do0 != 0 || nz_count(s0) != 0) begin
      miscompares++;
      $display("[TB] FAIL mid_discard: got uf %0d ones %0d data %0d expected 3 0 0", uf_cnt - uf0, dout_ones - do0, nz_count(s0));
    end
  endtask

  task automatic test_div2();
    int bper, wper, s0, dc0, db0;
    logic [31:0] p;
    bit ok1, ok2;
    hold_reset(1'b1);
    @(posedge mclk); #1;
    observe(300, bper, wper);
    vectors++;
    if (bper != 4 || wper != 128) begin
      miscompares++;
      $display("[TB] FAIL div2_timing: got %0d/%0d expected 4/128", bper, wper);
    end
    s0 = dec_q.size(); dc0 = dout_chg; db0 = dout_bad;
    p = rand_pair();
    send_pair(32'h8000_7FFF, ok1);
    send_pair(p, ok2);
    repeat (4 * 128) @(posedge mclk);
    vectors++;
    if (!ok1 || !ok2 || nz_count(s0) != 2 || nz_at(s0, 0) !== 32'h8000_7FFF || nz_at(s0, 1) !== p) begin
      miscompares++;
      $display("[TB] FAIL div2_data: got %0d: %h %h expected 2: 80007fff %h", nz_count(s0), nz_at(s0, 0), nz_at(s0, 1), p);
    end
    vectors++;
    if (dout_chg - dc0 == 0 || dout_bad - db0 != 0) begin
      miscompares++;
      $display("[TB] FAIL div2_dout_edge: got %0d stray of %0d edges expected 0 stray", dout_bad - db0, dout_chg - dc0);
    end
  endtask

  initial begin
    sel = 1'b0; drv_valid = 1'b0; drv_l = '0; drv_r = '0; reset_n = 1'b0;
    test_reset();
    test_loopback();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    test_div2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
